// File: rtl/integrator_pkg.sv
// integrator_pkg: shared defaults, mode encoding and clog2 for the integrate-and-dump slice
package integrator_pkg;
  localparam int DEF_WORD_LENGTH = 8;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DUMP_LEN = 4;
  typedef enum logic {MODE_CONT = 1'b0, MODE_DUMP = 1'b1} mode_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/integrator_lane.sv
// integrator_lane: one channel accumulator with output register and optional saturation (INTEGRATOR_SAT_EN)
module integrator_lane
  import integrator_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ACC_LENGTH = DEF_WORD_LENGTH + clog2(DEF_DUMP_LEN)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   accept,
  input  logic                   dump,
  input  logic                   load,
  input  logic [WORD_LENGTH-1:0] sample,
  output logic [ACC_LENGTH-1:0]  sum,
  output logic                   sat
);
`ifdef INTEGRATOR_SAT_EN
  localparam int RW = ACC_LENGTH + 1;
  logic sat_q, sat_d;
`else
  localparam int RW = ACC_LENGTH;
`endif
  logic [RW-1:0] raw;
  logic [ACC_LENGTH-1:0] acc_q, acc_d, sum_q, sum_d, next_sum;
  always_comb begin
    raw = RW'(acc_q) + RW'(sample);
`ifdef INTEGRATOR_SAT_EN
    next_sum = raw[ACC_LENGTH] ? '1 : raw[ACC_LENGTH-1:0];
    sat_d = sat_q | (accept & raw[ACC_LENGTH]);
`else
    next_sum = raw[ACC_LENGTH-1:0];
`endif
    acc_d = (clear || (accept && dump)) ? '0 : accept ? next_sum : acc_q;
    sum_d = load ? next_sum : sum_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      sum_q <= '0;
`ifdef INTEGRATOR_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
`ifdef INTEGRATOR_SAT_EN
      sat_q <= sat_d;
`endif
    end
  end
  assign sum = sum_q;
`ifdef INTEGRATOR_SAT_EN
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif
endmodule

// File: rtl/integrator_dump_mc.sv
// integrator_dump_mc: multi-channel integrate-and-dump / continuous integrator; INTEGRATOR_SAT_EN enables saturation
module integrator_dump_mc
  import integrator_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DUMP_LEN = DEF_DUMP_LEN,
  parameter int ACC_LENGTH = WORD_LENGTH + clog2(DUMP_LEN)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH*WORD_LENGTH-1:0] data_in,
  input  logic                         in_valid,
  input  logic                         hold,
  input  logic                         dump_mode,
  output logic [NUM_CH*ACC_LENGTH-1:0] data_out,
  output logic                         out_valid,
  output logic [NUM_CH-1:0]            sat_flag
);
  localparam int CW = clog2(DUMP_LEN);
  mode_e mode, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_chg, accept, last, load, out_valid_q, out_valid_d;
  always_comb begin
    mode = mode_e'(dump_mode);
    mode_chg = mode != prev_q;
    accept = in_valid && !hold && !mode_chg;
    last = (mode == MODE_DUMP) && (cnt_q == CW'(DUMP_LEN - 1));
    load = accept && ((mode == MODE_CONT) || last);
    cnt_d = (mode_chg || (accept && last)) ? '0 : (accept && mode == MODE_DUMP) ? cnt_q + 1'b1 : cnt_q;
    out_valid_d = load;
  end
  // mode is tracked every edge so a change is seen even across hold or reset
  always_ff @(posedge clock) begin
    prev_q <= mode;
    if (reset) begin
      cnt_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    integrator_lane #(.WORD_LENGTH(WORD_LENGTH), .ACC_LENGTH(ACC_LENGTH)) u_lane (
      .clock (clock),
      .reset (reset),
      .clear (mode_chg),
      .accept(accept),
      .dump  (last),
      .load  (load),
      .sample(data_in[c*WORD_LENGTH +: WORD_LENGTH]),
      .sum   (data_out[c*ACC_LENGTH +: ACC_LENGTH]),
      .sat   (sat_flag[c])
    );
  end
endmodule

// File: tb/tb_integrator_dump_mc.sv
// tb_integrator_dump_mc: scoreboard bench with a behavioural reference model for integrator_dump_mc
module tb_integrator_dump_mc;
  localparam int WL = 8;
  localparam int NCH = 2;
  localparam int DL = 4;
  localparam int ACC = 10;
  localparam longint MAXV = (64'd1 << ACC) - 1;
  logic clock = 1'b0;
  logic reset = 1'b1, in_valid = 1'b0, hold = 1'b0, dump_mode = 1'b1;
  logic [NCH*WL-1:0] data_in = '0;
  logic [NCH*ACC-1:0] data_out;
  logic out_valid;
  logic [NCH-1:0] sat_flag;
  integrator_dump_mc #(.WORD_LENGTH(WL), .NUM_CH(NCH), .DUMP_LEN(DL), .ACC_LENGTH(ACC)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid), .hold(hold),
    .dump_mode(dump_mode), .data_out(data_out), .out_valid(out_valid), .sat_flag(sat_flag)
  );
  always #5 clock = ~clock;
  typedef struct {
    int cyc;
    logic [NCH*ACC-1:0] d;
    logic [NCH-1:0] s;
  } exp_t;
  exp_t q[$];
  int total = 0, passed = 0, edges = 0;
  bit armed = 0;
  longint m_acc[NCH], m_out[NCH];
  bit m_sat[NCH];
  int m_n;
  bit m_prev;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  function automatic logic [NCH*ACC-1:0] pack_out();
    logic [NCH*ACC-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*ACC +: ACC] = ACC'(m_out[c]);
    return r;
  endfunction
  function automatic logic [NCH-1:0] pack_sat();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_sat[c];
    return r;
  endfunction
  function automatic logic [NCH*WL-1:0] pk(input int a, input int b);
    logic [NCH*WL-1:0] r;
    r[0 +: WL] = WL'(a);
    r[WL +: WL] = WL'(b);
    return r;
  endfunction
  // drive one cycle at the falling edge and advance the model to the following rising edge
  task automatic step(input bit rst, input bit iv, input bit h, input bit dm, input logic [NCH*WL-1:0] d);
    bit ov;
    longint s;
    exp_t e;
    @(negedge clock);
    reset = rst; in_valid = iv; hold = h; dump_mode = dm; data_in = d;
    ov = 0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin m_acc[c] = 0; m_out[c] = 0; m_sat[c] = 0; end
      m_n = 0;
      m_prev = dm;
    end else if (dm != m_prev) begin
      for (int c = 0; c < NCH; c++) m_acc[c] = 0;
      m_n = 0;
      m_prev = dm;
    end else if (iv && !h) begin
      for (int c = 0; c < NCH; c++) begin
        s = m_acc[c] + longint'(d[c*WL +: WL]);
`ifdef INTEGRATOR_SAT_EN
        if (s > MAXV) begin s = MAXV; m_sat[c] = 1; end
`else
        s = s % (MAXV + 1);
`endif
        m_acc[c] = s;
      end
      if (!dm) begin
        for (int c = 0; c < NCH; c++) m_out[c] = m_acc[c];
        ov = 1;
      end else begin
        m_n++;
        if (m_n == DL) begin
          for (int c = 0; c < NCH; c++) begin m_out[c] = m_acc[c]; m_acc[c] = 0; end
          m_n = 0;
          ov = 1;
        end
      end
    end
    if (ov) begin
      e.cyc = edges + 1; e.d = pack_out(); e.s = pack_sat();
      q.push_back(e);
    end
    armed = 1;
  endtask
  task automatic after_edge();
    @(posedge clock);
    #2;
  endtask
  initial begin : monitor
    exp_t e;
    bit due;
    forever begin
      @(posedge clock);
      edges++;
      #1;
      if (armed) begin
        due = q.size() > 0 && q[0].cyc == edges;
        chk("out_valid", longint'(out_valid), longint'(due));
        if (due) begin
          e = q.pop_front();
          if (out_valid) begin
            chk("dump_data", longint'(data_out), longint'(e.d));
            chk("dump_sat", longint'(sat_flag), longint'(e.s));
          end
        end
        chk("data_out_state", longint'(data_out), longint'(pack_out()));
        chk("sat_state", longint'(sat_flag), longint'(pack_sat()));
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin : stim
    bit dm, rst, iv, h;
    step(1, 0, 0, 1, '0);
    after_edge();
    chk("reset_data_out", longint'(data_out), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_sat", longint'(sat_flag), 0);
    // single dump frame
    step(0, 1, 0, 1, pk(8, 0)); step(0, 1, 0, 1, pk(47, 0));
    step(0, 1, 0, 1, pk(255, 0)); step(0, 1, 0, 1, pk(170, 0));
    after_edge();
    chk("frame_valid", longint'(out_valid), 1);
    chk("frame_ch0", longint'(data_out[0 +: ACC]), 480);
    step(0, 0, 0, 1, '0);
    after_edge();
    chk("between_valid", longint'(out_valid), 0);
    chk("between_ch0", longint'(data_out[0 +: ACC]), 480);
    // hold mid-frame
    step(0, 1, 0, 1, pk(8, 0)); step(0, 1, 0, 1, pk(47, 0));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 1, pk(99, 0));
      after_edge();
      chk("hold_no_pulse", longint'(out_valid), 0);
    end
    step(0, 1, 0, 1, pk(255, 0)); step(0, 1, 0, 1, pk(170, 0));
    after_edge();
    chk("hold_frame_valid", longint'(out_valid), 1);
    chk("hold_frame_ch0", longint'(data_out[0 +: ACC]), 480);
    // reset mid-frame
    step(0, 1, 0, 1, pk(100, 0)); step(0, 1, 0, 1, pk(100, 0));
    step(1, 1, 0, 1, pk(100, 0));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, pk(1, 0));
    after_edge();
    chk("rst_frame_valid", longint'(out_valid), 1);
    chk("rst_frame_ch0", longint'(data_out[0 +: ACC]), 4);
    chk("rst_frame_sat", longint'(sat_flag), 0);
    // continuous overflow
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, pk(255, 0));
    after_edge();
    chk("cont_valid", longint'(out_valid), 1);
`ifdef INTEGRATOR_SAT_EN
    chk("cont_sat_ch0", longint'(data_out[0 +: ACC]), 1023);
    chk("cont_sat_flag", longint'(sat_flag[0]), 1);
`else
    chk("cont_wrap_ch0", longint'(data_out[0 +: ACC]), 251);
    chk("cont_wrap_flag", longint'(sat_flag[0]), 0);
`endif
    // mode change discards the sample on the toggle edge
    step(1, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, pk(7, 3));
    step(0, 1, 0, 0, pk(9, 9));
    after_edge();
    chk("mode_chg_valid", longint'(out_valid), 0);
    chk("mode_chg_ch0", longint'(data_out[0 +: ACC]), 0);
    step(0, 1, 0, 0, pk(5, 0));
    after_edge();
    chk("mode_next_valid", longint'(out_valid), 1);
    chk("mode_next_ch0", longint'(data_out[0 +: ACC]), 5);
    chk("mode_next_ch1", longint'(data_out[ACC +: ACC]), 0);
    // channel independence
    step(1, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, pk(1, 2));
    after_edge();
    chk("indep_ch0", longint'(data_out[0 +: ACC]), 4);
    chk("indep_ch1", longint'(data_out[ACC +: ACC]), 8);
    // randomized traffic
    dm = 1;
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) < 2;
      if ($urandom_range(0, 99) < 4) dm = ~dm;
      iv = $urandom_range(0, 99) < 70;
      h = $urandom_range(0, 99) < 20;
      step(rst, iv, h, dm, pk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255))));
    end
    step(0, 0, 0, dm, '0);
    step(0, 0, 0, dm, '0);
    after_edge();
    chk("queue_drained", longint'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
